scaled_image_renderer: RTL and testbench
========================================

Name: scaled_image_renderer

Overview:
- Parametrised successor of the full-screen ROM+palette background drawer.
- Places an IMG_W×IMG_H palette-indexed image at a runtime position, with power-of-two upscaling, optional horizontal mirroring and a transparent index.
- Drives an external synchronous image ROM and reads an external combinational palette.
- Outputs pipelined, blank-gated RGB plus a hit flag, so a downstream compositor can layer several instances, e.g. background plus fruit sprites.

Parameters:
- IMG_W, 640, source image width in pixels.
- IMG_H, 480, source image height in pixels.
- ADDR_W, 19, ROM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- IDX_W, 8, palette index width.
- SCALE_SHIFT, 0, each source pixel is drawn as a 2^SCALE_SHIFT square.
- ROM_LATENCY, 1, vga_clk edges from rom_addr change to valid rom_q (1..3).
- TRANSPARENT_IDX, 0, palette index treated as transparent.
- USE_TRANSPARENT, 1, 0 disables transparency.
- LATCH_LINE, 480, DrawY value at which shadow registers update (first blanked line).

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = visible region.
- pos_x  in  10  requested image left edge in screen pixels.
- pos_y  in  10  requested image top edge.
- mirror_x  in  1  requested horizontal mirror.
- enable  in  1  requested layer enable.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  IDX_W  ROM data.
- pal_index  out  IDX_W  index to external palette.
- pal_red / pal_green / pal_blue  in  4 each  combinational palette output.
- red / green / blue  out  4 each  registered pixel colour.
- hit  out  1  registered: pixel is inside the image, opaque, enabled and visible.

Behaviour:
- Reset (async, reset_n=0):
  - rom_addr=0, red/green/blue=0, hit=0.
  - All pipeline valid bits = 0.
  - Shadow regs: pos_x_s=0, pos_y_s=0, mirror_s=0, enable_s=0.
  - Deassertion is synchronised by the sampling edge only; no other reset behaviour.
- Shadow registers:
  - Load pos_x/pos_y/mirror_x/enable at the edge where DrawX==0 && DrawY==LATCH_LINE.
  - Otherwise hold, so a frame never tears mid-draw.
  - Changing inputs at any other time has no effect until the next latch point.
- Stage 0 (edge k, samples DrawX/DrawY/blank):
  - dx = DrawX−pos_x_s, dy = DrawY−pos_y_s, computed 11-bit signed.
  - inside = dx≥0, dy≥0, dx < IMG_W<<SCALE_SHIFT, dy < IMG_H<<SCALE_SHIFT.
  - u = dx>>SCALE_SHIFT, v = dy>>SCALE_SHIFT.
  - If mirror_s, u := IMG_W−1−u.
  - rom_addr <= inside ? v*IMG_W+u : rom_addr (hold to avoid needless toggling).
  - Register inside&enable_s&blank as the stage valid.
  - Multiplier or incremental row-base counter are both allowed; the result must be identical.
- Delay line: valid and blank are delayed ROM_LATENCY edges so they align with rom_q after edge k+ROM_LATENCY.
- pal_index = rom_q, combinational.
- Output stage (edge k+ROM_LATENCY+1):
  - opaque = !(USE_TRANSPARENT && rom_q==TRANSPARENT_IDX).
  - hit <= valid_d && opaque.
  - RGB <= hit_next ? pal_* : 0.
  - With blank_d==0, RGB=0 and hit=0 regardless.
- Total latency: ROM_LATENCY+1 edges after the sampling edge; fixed, with no bubbles. The caller delays hsync/vsync by the same amount.
- Boundary cases:
  - An image partly off-screen (pos_x+width>639) is clipped naturally.
  - pos_x/pos_y ≥ 640/480 means nothing is drawn.
  - The last source column and row map exactly to address IMG_W*IMG_H−1.
  - Reset mid-frame gives hit=0 until a pixel arrives after the next latch line with enable asserted.

Decomposition:
- Shared package video_pkg:
  - H_ACTIVE=640, V_ACTIVE=480, COORD_W=10, RGB_W=4.
  - typedef rgb444_t {r,g,b}.
- One sub-module: pipe_delay (parametrised WIDTH, DEPTH shift register with async active-low reset), used for the valid/blank alignment.

Test Plan:
- Common setup: ROM model returns (addr mod 256), ROM_LATENCY=1, identity palette (r=idx[7:4], g=idx[3:0], b=0).
- Latency: defaults, pos=(0,0), enable=1, DrawX=5, DrawY=2, blank=1 at edge k → rom_addr=1285 after edge k; red=4'h0 green=4'h5 hit=1 after edge k+2.
- Scaling: IMG_W=32, IMG_H=16, SCALE_SHIFT=2, pos=(100,50). DrawX=107, DrawY=58 → addr 2*32+1=65. DrawX=227 (dx=127) → addr 95. DrawX=228 → hit=0, RGB=0.
- Mirror: same config, mirror_x=1 latched. DrawX=100, DrawY=50 → addr 31; DrawX=227 → addr 0.
- Transparency: ROM forced to 0 at addr 65 → hit=0, RGB=0. Set USE_TRANSPARENT=0 → hit=1.
- Shadow latch: change pos_x at DrawY=200 → addresses are unchanged for the rest of that frame and shift only after DrawX=0, DrawY=480. Same check for enable.
- Reset/blank: assert reset_n=0 mid-line → all outputs 0 immediately, asynchronously. blank=0 with an inside coordinate → RGB=0 and hit=0 after 2 edges.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants and the 12-bit colour type used by the layer renderers.
package video_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;
    localparam int RGB_W    = 4;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb444_t;
endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register used to line sideband bits up with ROM read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] r_q;
        if (gi == 0) begin : g_head
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_q <= '0;
                else          r_q <= i_d;
            end
        end else begin : g_tail
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_q <= '0;
                else          r_q <= g_stage[gi-1].r_q;
            end
        end
    end

    assign o_q = g_stage[DEPTH-1].r_q;
endmodule

// File: rtl/scaled_image_renderer.sv
// One palette-indexed image layer: positions, upscales and optionally mirrors a ROM
// image, producing blank-gated RGB plus a hit flag for a downstream compositor.
module scaled_image_renderer
    import video_pkg::*;
#(
    parameter int IMG_W           = H_ACTIVE,
    parameter int IMG_H           = V_ACTIVE,
    parameter int ADDR_W          = 19,
    parameter int IDX_W           = 8,
    parameter int SCALE_SHIFT     = 0,
    parameter int ROM_LATENCY     = 1,
    parameter int TRANSPARENT_IDX = 0,
    parameter int USE_TRANSPARENT = 1,
    parameter int LATCH_LINE      = V_ACTIVE
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               blank,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               mirror_x,
    input  logic               enable,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_index,
    input  logic [RGB_W-1:0]   pal_red,
    input  logic [RGB_W-1:0]   pal_green,
    input  logic [RGB_W-1:0]   pal_blue,
    output logic [RGB_W-1:0]   red,
    output logic [RGB_W-1:0]   green,
    output logic [RGB_W-1:0]   blue,
    output logic               hit
);
    localparam int                 SPAN_W = IMG_W << SCALE_SHIFT;
    localparam int                 SPAN_H = IMG_H << SCALE_SHIFT;
    localparam logic [COORD_W-1:0] U_LAST = COORD_W'(IMG_W - 1);

    logic [COORD_W-1:0] r_pos_x_s, r_pos_y_s;
    logic               r_mirror_s, r_enable_s;

    // Placement only changes on the first blanked line so a frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos_x_s  <= '0;
            r_pos_y_s  <= '0;
            r_mirror_s <= 1'b0;
            r_enable_s <= 1'b0;
        end else if (DrawX == '0 && DrawY == COORD_W'(LATCH_LINE)) begin
            r_pos_x_s  <= pos_x;
            r_pos_y_s  <= pos_y;
            r_mirror_s <= mirror_x;
            r_enable_s <= enable;
        end
    end

    logic signed [COORD_W:0] w_dx, w_dy;
    logic [COORD_W-1:0]      w_u, w_v, w_u_m;
    logic                    w_inside, w_valid0;
    logic [ADDR_W-1:0]       w_addr;

    assign w_dx     = $signed({1'b0, DrawX}) - $signed({1'b0, r_pos_x_s});
    assign w_dy     = $signed({1'b0, DrawY}) - $signed({1'b0, r_pos_y_s});
    assign w_inside = !w_dx[COORD_W] && !w_dy[COORD_W]
                   && (int'(w_dx[COORD_W-1:0]) < SPAN_W)
                   && (int'(w_dy[COORD_W-1:0]) < SPAN_H);
    assign w_u      = w_dx[COORD_W-1:0] >> SCALE_SHIFT;
    assign w_v      = w_dy[COORD_W-1:0] >> SCALE_SHIFT;
    assign w_u_m    = r_mirror_s ? (U_LAST - w_u) : w_u;
    assign w_addr   = ADDR_W'(w_v) * ADDR_W'(IMG_W) + ADDR_W'(w_u_m);
    assign w_valid0 = w_inside & r_enable_s & blank;

    logic r_valid0, r_blank0;

    // Address holds outside the image to keep the ROM bus quiet.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            r_valid0 <= 1'b0;
            r_blank0 <= 1'b0;
        end else begin
            if (w_inside) rom_addr <= w_addr;
            r_valid0 <= w_valid0;
            r_blank0 <= blank;
        end
    end

    logic w_valid_d, w_blank_d;

    pipe_delay #(
        .WIDTH(2),
        .DEPTH(ROM_LATENCY)
    ) u_align (
        .i_clk  (vga_clk),
        .i_rst_n(reset_n),
        .i_d    ({r_valid0, r_blank0}),
        .o_q    ({w_valid_d, w_blank_d})
    );

    logic    w_opaque, w_hit_next;
    rgb444_t r_rgb;

    assign pal_index  = rom_q;
    assign w_opaque   = !((USE_TRANSPARENT != 0) && (rom_q == IDX_W'(TRANSPARENT_IDX)));
    assign w_hit_next = w_valid_d & w_blank_d & w_opaque;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit   <= 1'b0;
            r_rgb <= '0;
        end else begin
            hit   <= w_hit_next;
            r_rgb <= w_hit_next ? rgb444_t'{pal_red, pal_green, pal_blue} : '0;
        end
    end

    assign red   = r_rgb.r;
    assign green = r_rgb.g;
    assign blue  = r_rgb.b;
endmodule

// File: tb/tb_scaled_image_renderer.sv
// Scoreboard bench: three renderer instances (full-screen, 4x-scaled, 4x-scaled opaque)
// sharing one video timing stream, each backed by a 1-cycle ROM and identity palette.
module tb_scaled_image_renderer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
    logic       blank = 1'b0, mirror_x = 1'b0, enable = 1'b0;
    logic       force_zero = 1'b0;

    logic [18:0] rom_addr_w [3];
    logic [7:0]  rom_q_w    [3];
    logic [7:0]  pal_idx_w  [3];
    logic [3:0]  pr_w [3], pg_w [3], pb_w [3];
    logic [3:0]  red_w [3], grn_w [3], blu_w [3];
    logic        hit_w [3];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        int          inst;
        logic [18:0] addr;
        logic        hit;
        logic [3:0]  r, g, b;
        string       tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_o[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM returns addr mod 256; instances 1/2 can have address 65 forced to index 0.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            rom_q_w[i] <= (force_zero && i != 0 && rom_addr_w[i] == 19'd65) ? 8'd0 : rom_addr_w[i][7:0];
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pr_w[i] = pal_idx_w[i][7:4];
            pg_w[i] = pal_idx_w[i][3:0];
            pb_w[i] = 4'h0;
        end
    end

    scaled_image_renderer u_full (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .mirror_x(mirror_x), .enable(enable),
        .rom_addr(rom_addr_w[0]), .rom_q(rom_q_w[0]), .pal_index(pal_idx_w[0]),
        .pal_red(pr_w[0]), .pal_green(pg_w[0]), .pal_blue(pb_w[0]),
        .red(red_w[0]), .green(grn_w[0]), .blue(blu_w[0]), .hit(hit_w[0])
    );

    scaled_image_renderer #(.IMG_W(32), .IMG_H(16), .SCALE_SHIFT(2)) u_scl (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .mirror_x(mirror_x), .enable(enable),
        .rom_addr(rom_addr_w[1]), .rom_q(rom_q_w[1]), .pal_index(pal_idx_w[1]),
        .pal_red(pr_w[1]), .pal_green(pg_w[1]), .pal_blue(pb_w[1]),
        .red(red_w[1]), .green(grn_w[1]), .blue(blu_w[1]), .hit(hit_w[1])
    );

    scaled_image_renderer #(.IMG_W(32), .IMG_H(16), .SCALE_SHIFT(2), .USE_TRANSPARENT(0)) u_opq (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .mirror_x(mirror_x), .enable(enable),
        .rom_addr(rom_addr_w[2]), .rom_q(rom_q_w[2]), .pal_index(pal_idx_w[2]),
        .pal_red(pr_w[2]), .pal_green(pg_w[2]), .pal_blue(pb_w[2]),
        .red(red_w[2]), .green(grn_w[2]), .blue(blu_w[2]), .hit(hit_w[2])
    );

    // Address is due one edge after sampling, pixel output three negedges later.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (q_a.size() > 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            n_tests++;
            if (e.due != cyc || rom_addr_w[e.inst] !== e.addr) begin
                n_fail++;
                $display("FAIL %s inst%0d rom_addr: got %0d, want %0d (due %0d, now %0d)",
                         e.tag, e.inst, rom_addr_w[e.inst], e.addr, e.due, cyc);
            end
        end
        while (q_o.size() > 0 && q_o[0].due <= cyc) begin
            e = q_o.pop_front();
            n_tests++;
            if (e.due != cyc || hit_w[e.inst] !== e.hit || red_w[e.inst] !== e.r
                || grn_w[e.inst] !== e.g || blu_w[e.inst] !== e.b) begin
                n_fail++;
                $display("FAIL %s inst%0d pixel: got hit=%b rgb=%h%h%h, want hit=%b rgb=%h%h%h",
                         e.tag, e.inst, hit_w[e.inst], red_w[e.inst], grn_w[e.inst], blu_w[e.inst],
                         e.hit, e.r, e.g, e.b);
            end
        end
    end

    task automatic expect_px(input int inst, input bit chk_addr, input logic [18:0] a,
                             input bit h, input string tag);
        exp_t       e;
        logic [7:0] idx;
        idx    = (force_zero && inst != 0 && a == 19'd65) ? 8'd0 : a[7:0];
        e.inst = inst;
        e.addr = a;
        e.tag  = tag;
        e.due  = cyc + 1;
        e.hit  = 1'b0;
        e.r    = '0;
        e.g    = '0;
        e.b    = '0;
        if (chk_addr) q_a.push_back(e);
        e.due = cyc + 3;
        e.hit = h;
        e.r   = h ? idx[7:4] : 4'h0;
        e.g   = h ? idx[3:0] : 4'h0;
        q_o.push_back(e);
    endtask

    task automatic step(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic latch(input int px, input int py, input bit m, input bit en);
        pos_x    = 10'(px);
        pos_y    = 10'(py);
        mirror_x = m;
        enable   = en;
        step(0, 480, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({rom_addr_w[i], red_w[i], grn_w[i], blu_w[i], hit_w[i]} !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got addr=%0d rgb=%h%h%h hit=%b, want all 0",
                         i, rom_addr_w[i], red_w[i], grn_w[i], blu_w[i], hit_w[i]);
            end
        end
    endtask

    task automatic test_latency;
        latch(0, 0, 1'b0, 1'b1);
        expect_px(0, 1'b1, 19'd1285, 1'b1, "latency");
        step(5, 2, 1'b1);
        idle(3);
    endtask

    task automatic test_boundary;
        expect_px(0, 1'b1, 19'd307199, 1'b1, "last_pixel");
        step(639, 479, 1'b1);
        expect_px(0, 1'b1, 19'd0, 1'b0, "first_pixel_transparent");
        step(0, 0, 1'b1);
        latch(600, 0, 1'b0, 1'b1);
        expect_px(0, 1'b1, 19'd679, 1'b1, "clipped_right");
        step(639, 1, 1'b1);
        latch(640, 0, 1'b0, 1'b1);
        expect_px(0, 1'b0, 19'd0, 1'b0, "pos_x_offscreen");
        step(639, 10, 1'b1);
        latch(0, 480, 1'b0, 1'b1);
        expect_px(0, 1'b0, 19'd0, 1'b0, "pos_y_offscreen");
        step(10, 479, 1'b1);
        idle(3);
    endtask

    task automatic test_scaling;
        latch(100, 50, 1'b0, 1'b1);
        expect_px(1, 1'b1, 19'd65, 1'b1, "scale_65");
        expect_px(2, 1'b1, 19'd65, 1'b1, "scale_65_opq");
        step(107, 58, 1'b1);
        expect_px(1, 1'b1, 19'd95, 1'b1, "scale_last_col");
        step(227, 58, 1'b1);
        expect_px(1, 1'b0, 19'd0, 1'b0, "scale_right_edge");
        step(228, 58, 1'b1);
        expect_px(1, 1'b0, 19'd0, 1'b0, "scale_left_edge");
        step(99, 58, 1'b1);
        expect_px(1, 1'b0, 19'd0, 1'b0, "scale_top_edge");
        step(107, 49, 1'b1);
        expect_px(1, 1'b1, 19'd481, 1'b1, "scale_last_row");
        step(107, 113, 1'b1);
        expect_px(1, 1'b0, 19'd0, 1'b0, "scale_bottom_edge");
        step(107, 114, 1'b1);
        idle(3);
    endtask

    task automatic test_mirror;
        latch(100, 50, 1'b1, 1'b1);
        expect_px(1, 1'b1, 19'd31, 1'b1, "mirror_left");
        expect_px(2, 1'b1, 19'd31, 1'b1, "mirror_left_opq");
        step(100, 50, 1'b1);
        expect_px(1, 1'b1, 19'd0, 1'b0, "mirror_right_transparent");
        expect_px(2, 1'b1, 19'd0, 1'b1, "mirror_right_opq");
        step(227, 50, 1'b1);
        expect_px(1, 1'b1, 19'd94, 1'b1, "mirror_inner");
        step(107, 58, 1'b1);
        idle(3);
    endtask

    task automatic test_transparency;
        force_zero = 1'b1;
        latch(100, 50, 1'b0, 1'b1);
        expect_px(1, 1'b1, 19'd65, 1'b0, "transparent_idx");
        expect_px(2, 1'b1, 19'd65, 1'b1, "transparency_off");
        step(107, 58, 1'b1);
        idle(3);
        force_zero = 1'b0;
    endtask

    task automatic test_shadow_latch;
        latch(0, 0, 1'b0, 1'b1);
        expect_px(0, 1'b1, 19'd128010, 1'b1, "shadow_pre");
        step(10, 200, 1'b1);
        pos_x = 10'd8;
        expect_px(0, 1'b1, 19'd128020, 1'b1, "shadow_hold_pos");
        step(20, 200, 1'b1);
        enable = 1'b0;
        expect_px(0, 1'b1, 19'd128030, 1'b1, "shadow_hold_enable");
        step(30, 200, 1'b1);
        latch(8, 0, 1'b0, 1'b0);
        expect_px(0, 1'b1, 19'd128012, 1'b0, "shadow_new_pos_disabled");
        step(20, 200, 1'b1);
        latch(8, 0, 1'b0, 1'b1);
        expect_px(0, 1'b1, 19'd128012, 1'b1, "shadow_reenabled");
        step(20, 200, 1'b1);
        idle(3);
    endtask

    task automatic test_blank;
        latch(0, 0, 1'b0, 1'b1);
        expect_px(0, 1'b1, 19'd1285, 1'b0, "blank_low");
        step(5, 2, 1'b0);
        idle(3);
    endtask

    task automatic test_reset_midline;
        latch(0, 0, 1'b0, 1'b1);
        DrawX = 10'd10;
        DrawY = 10'd3;
        blank = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (hit_w[0] !== 1'b1 || red_w[0] !== 4'h8 || grn_w[0] !== 4'hA) begin
            n_fail++;
            $display("FAIL pre_reset_pixel: got hit=%b rgb=%h%h, want hit=1 rgb=8A",
                     hit_w[0], red_w[0], grn_w[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({rom_addr_w[0], red_w[0], grn_w[0], blu_w[0], hit_w[0]} !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%0d rgb=%h%h%h hit=%b, want all 0",
                     rom_addr_w[0], red_w[0], grn_w[0], blu_w[0], hit_w[0]);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        expect_px(0, 1'b1, 19'd1930, 1'b0, "post_reset_disabled");
        step(10, 3, 1'b1);
        latch(0, 0, 1'b0, 1'b1);
        expect_px(0, 1'b1, 19'd1930, 1'b1, "post_reset_latched");
        step(10, 3, 1'b1);
        idle(3);
    endtask

    task automatic test_back_to_back;
        logic [18:0] a;
        int          x, y;
        latch(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 479));
            a = 19'(y * 640 + x);
            expect_px(0, 1'b1, a, a[7:0] != 8'd0, "back_to_back");
            step(x, y, 1'b1);
        end
        idle(4);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_latency();
        test_boundary();
        test_scaling();
        test_mirror();
        test_transparency();
        test_shadow_latch();
        test_blank();
        test_reset_midline();
        test_back_to_back();
        idle(2);
        n_tests++;
        if (q_a.size() != 0 || q_o.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q_a.size() + q_o.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end
endmodule
